aes_key_sched_ctrl: RTL and testbench
=====================================

AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001 clk  in  1  system clock; all state on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 start  in  1  begin expansion of key; sampled only in IDLE.
REQ-004 key  in  128  cipher key, sampled when start is accepted.
REQ-005 abort  in  1  synchronous cancel of any operation.
REQ-006 replay  in  1  re-stream cached round keys (AES_KEY_CACHE_EN only).
REQ-007 ke_load  out  1  datapath load strobe.
REQ-008 ke_step  out  1  datapath one-round advance strobe; the datapath holds when ke_load=ke_step=0.
REQ-009 ke_key_in  out  128  key to datapath.
REQ-010 ke_rcon  out  32  {rcon,24'h0} to datapath.
REQ-011 ke_key_out  in  128  current datapath round key.
REQ-012 rk_valid/rk_ready  out/in  1/1  round-key stream handshake.
REQ-013 rk_data  out  128  round key; rk_idx  out  4  round number 0..10.
REQ-014 busy  out  1  not IDLE; done  out  1  one-cycle completion pulse.

Function
REQ-015 FSM states: IDLE, LOAD, EMIT, SBOX, STEP, DONE, plus REPLAY when the cache is compiled in.
REQ-016 IDLE: start=1 -> LOAD, latches key, round=0, rcon=8'h01; start has priority over replay.
REQ-017 LOAD: ke_load=1, ke_key_in=latched key for exactly one cycle -> EMIT.
REQ-018 EMIT: rk_valid=1, rk_data=ke_key_out, rk_idx=round; holds with stable data until rk_ready; on handshake, round==10 -> DONE, else -> SBOX.
REQ-019 SBOX: one idle cycle covering the clocked S-box lookup latency -> STEP.
REQ-020 STEP: ke_step=1, ke_rcon={rcon,24'h0} for one cycle; round+=1; rcon=xtime(rcon) = (rcon<<1) ^ (rcon[7] ? 8'h1b : 0) -> EMIT.
REQ-021 rcon sequence SHALL be 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
REQ-022 Latency with rk_ready held at 1 and start at cycle 0:
- round r valid at cycle 2+3r;
- round 10 at cycle 32;
- done at cycle 33;
- then IDLE.
REQ-023 Backpressure: rk_ready=0 stalls only EMIT; ke_step SHALL NOT assert while an emitted key is unaccepted.
REQ-024 DONE: done=1 for one cycle -> IDLE.
REQ-025 start while busy is ignored; replay while busy is ignored.
REQ-026 abort=1 in any state -> IDLE next cycle: rk_valid, ke_load and ke_step deassert, no done pulse; abort wins over start in the same cycle.
REQ-027 In all non-active states, ke_load, ke_step, rk_valid and done are 0, and ke_rcon is 0.

Reset
REQ-028 rst SHALL asynchronously force IDLE, round=0, rcon=8'h01, and all outputs 0 (rk_data, rk_idx, ke_key_in, ke_rcon, busy, done, ke_load, ke_step, rk_valid); with the cache compiled in, cache_valid=0.
REQ-029 Reset mid-operation abandons expansion; the first post-reset start behaves as from power-up.

Configuration
REQ-030 Macro AES_KEY_CACHE_EN defined:
- 11x128 buffer written at each EMIT handshake;
- cache_valid set when the round-10 handshake occurs, cleared by start, abort or reset;
- replay in IDLE with cache_valid -> REPLAY;
- REPLAY streams entries 0..10 with the same EMIT handshake rules, no datapath strobes, then DONE.
REQ-031 Macro undefined: no buffer, no REPLAY state, replay input ignored.

Structure
REQ-032 Shared package aes_pkg: AES_NR=10, RCON_INIT=8'h01, RCON_POLY=8'h1b, the FSM state enum type, round index type (4 bits).
REQ-033 One sub-module, aes_rcon_gen: registered rcon with init/advance inputs implementing REQ-020/021.

Verification
REQ-034 Start with FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c and rk_ready=1, using the golden datapath model:
- idx0 = key;
- idx1 = a0fafe1788542cb123a339392a6c7605;
- idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at cycle 32;
- done at cycle 33.
REQ-035 Random rk_ready deassertion (~50%) -> identical 11 keys in order, rk_data stable while stalled, no ke_step during a stall.
REQ-036 Abort asserted during round 4 SBOX -> IDLE next cycle, no done; a new start produces a correct full sequence.
REQ-037 rst asserted during round 7 EMIT -> all outputs 0 immediately; a start pulse during busy is ignored (single done only).
REQ-038 AES_KEY_CACHE_EN: after a full run, replay -> 11 identical keys with ke_load=ke_step=0 throughout; replay after abort (cache invalid) -> no response.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared constants, FSM state type and rcon helper for the AES-128 key schedule controller.
// The REPLAY state exists only when AES_KEY_CACHE_EN is defined.
package aes_pkg;
    localparam int         AES_NR    = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;
    typedef logic [3:0] round_t;
`ifdef AES_KEY_CACHE_EN
    typedef enum logic [2:0] {IDLE, LOAD, EMIT, SBOX, STEP, DONE, REPLAY} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, EMIT, SBOX, STEP, DONE} state_t;
`endif
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction
endpackage

// File: rtl/aes_rcon_gen.sv
// aes_rcon_gen: round-constant register, restarts at 01 on init and advances by xtime on adv.
module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_init,
    input  logic       i_adv,
    output logic [7:0] o_rcon
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            o_rcon <= RCON_INIT;
        else if (i_init)
            o_rcon <= RCON_INIT;
        else if (i_adv)
            o_rcon <= xtime(o_rcon);
    end
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: drives an external AES-128 key-expansion datapath and streams round keys 0..10.
// Define AES_KEY_CACHE_EN to add an 11-entry round-key cache that can be re-streamed with replay.
module aes_key_sched_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic         abort,
    input  logic         replay,
    output logic         ke_load,
    output logic         ke_step,
    output logic [127:0] ke_key_in,
    output logic [31:0]  ke_rcon,
    input  logic [127:0] ke_key_out,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done
);
    localparam round_t LAST = round_t'(AES_NR);

    state_t     r_state;
    round_t     r_round;
    logic [7:0] w_rcon;
    logic       w_init;
    logic       w_adv;

    assign w_init = (r_state == IDLE) && start && !abort;
    assign w_adv  = (r_state == STEP) && !abort;
    assign rk_idx = r_round;

    aes_rcon_gen u_rcon (
        .clk    (clk),
        .rst    (rst),
        .i_init (w_init),
        .i_adv  (w_adv),
        .o_rcon (w_rcon)
    );

`ifdef AES_KEY_CACHE_EN
    logic [127:0] r_cache [0:AES_NR];
    logic         r_cache_valid;

    always_ff @(posedge clk) begin
        if (r_state == EMIT && rk_ready && !abort)
            r_cache[r_round] <= ke_key_out;
    end

    // Valid only once a full expansion has been accepted; any new start or abort invalidates it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cache_valid <= 1'b0;
        else if (abort || w_init)
            r_cache_valid <= 1'b0;
        else if (r_state == EMIT && rk_ready && r_round == LAST)
            r_cache_valid <= 1'b1;
    end

    assign rk_data = !rk_valid ? '0 : (r_state == REPLAY) ? r_cache[r_round] : ke_key_out;
`else
    logic w_unused;
    assign w_unused = replay;
    assign rk_data  = rk_valid ? ke_key_out : '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_round   <= '0;
            ke_load   <= 1'b0;
            ke_step   <= 1'b0;
            ke_key_in <= '0;
            ke_rcon   <= '0;
            rk_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            r_state   <= IDLE;
            r_round   <= '0;
            ke_load   <= 1'b0;
            ke_step   <= 1'b0;
            ke_key_in <= '0;
            ke_rcon   <= '0;
            rk_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state   <= LOAD;
                    r_round   <= '0;
                    ke_load   <= 1'b1;
                    ke_key_in <= key;
                    busy      <= 1'b1;
                end
`ifdef AES_KEY_CACHE_EN
                else if (replay && r_cache_valid) begin
                    r_state  <= REPLAY;
                    r_round  <= '0;
                    rk_valid <= 1'b1;
                    busy     <= 1'b1;
                end
`endif
                LOAD: begin
                    r_state   <= EMIT;
                    ke_load   <= 1'b0;
                    ke_key_in <= '0;
                    rk_valid  <= 1'b1;
                end
                EMIT: if (rk_ready) begin
                    r_state  <= (r_round == LAST) ? DONE : SBOX;
                    rk_valid <= 1'b0;
                    done     <= (r_round == LAST);
                end
                // The datapath's S-box result is ready one cycle after the key is emitted.
                SBOX: begin
                    r_state <= STEP;
                    ke_step <= 1'b1;
                    ke_rcon <= {w_rcon, 24'h0};
                end
                STEP: begin
                    r_state  <= EMIT;
                    ke_step  <= 1'b0;
                    ke_rcon  <= '0;
                    r_round  <= r_round + 1'b1;
                    rk_valid <= 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_round <= '0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
`ifdef AES_KEY_CACHE_EN
                REPLAY: if (rk_ready) begin
                    if (r_round == LAST) begin
                        r_state  <= DONE;
                        rk_valid <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        r_round <= r_round + 1'b1;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: scoreboard bench with a behavioural AES-128 key-expansion datapath and reference schedule.
module tb_aes_key_sched_ctrl;
    logic         clk = 1'b0;
    logic         rst, start, abort, replay, rk_ready;
    logic [127:0] key;
    logic         ke_load, ke_step, rk_valid, busy, done;
    logic [127:0] ke_key_in, ke_key_out, rk_data;
    logic [31:0]  ke_rcon;
    logic [3:0]   rk_idx;

    aes_key_sched_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .abort(abort), .replay(replay),
        .ke_load(ke_load), .ke_step(ke_step), .ke_key_in(ke_key_in), .ke_rcon(ke_rcon),
        .ke_key_out(ke_key_out), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
        .rk_idx(rk_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] FKEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    typedef struct {logic [127:0] d; int idx; int cyc;} exp_t;
    exp_t q[$];
    int   dq[$];
    int   n_vec, n_err, cyc, rmode;
    bit   in_replay;
    logic [7:0]   sbox [256];
    logic [127:0] dp, last_k;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // Whole FIPS-197 word expansion with the round constants written out as a table.
    function automatic logic [127:0] ref_key(input logic [127:0] k, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rct [10];
        rct = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = subw({t[23:0], t[31:24]}) ^ {rct[i/4-1], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] dp_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = subw({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Golden datapath: loads on ke_load, advances one round with the controller's rcon on ke_step.
    always @(posedge clk) begin
        if (ke_load) dp <= ke_key_in;
        else if (ke_step) dp <= dp_next(dp, ke_rcon[31:24]);
    end
    assign ke_key_out = dp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 128'(busy), 0);
        chk({tag, "_done"}, 128'(done), 0);
        chk({tag, "_rk_valid"}, 128'(rk_valid), 0);
        chk({tag, "_ke_load"}, 128'(ke_load), 0);
        chk({tag, "_ke_step"}, 128'(ke_step), 0);
        chk({tag, "_ke_rcon"}, 128'(ke_rcon), 0);
        chk({tag, "_ke_key_in"}, ke_key_in, 0);
        chk({tag, "_rk_data"}, rk_data, 0);
        chk({tag, "_rk_idx"}, 128'(rk_idx), 0);
    endtask

    task automatic start_run(input logic [127:0] k, input int nexp, input bit timed,
                             input bit want_done, input bit fips, output int s);
        @(posedge clk); #1;
        s = cyc;
        start = 1'b1;
        key = k;
        for (int r = 0; r < nexp; r++) begin
            exp_t e;
            e.d = ref_key(k, r);
            if (fips && r == 1) e.d = FIPS1;
            if (fips && r == 10) e.d = FIPS10;
            e.idx = r;
            e.cyc = timed ? s + 2 + 3*r : -1;
            q.push_back(e);
        end
        if (want_done) dq.push_back(timed ? s + 33 : -1);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 3000);
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
        end
    endtask

    task automatic no_resp(input string tag);
        @(posedge clk); #1;
        replay = 1'b1;
        @(posedge clk); #1;
        replay = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk({tag, "_busy"}, 128'(busy), 0);
            chk({tag, "_rk_valid"}, 128'(rk_valid), 0);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        forever begin
            @(posedge clk); #1;
            rk_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Monitor: pops the scoreboard on every accepted key and done pulse, and polices stalls.
    initial begin
        logic [127:0] prev_d;
        bit pend;
        exp_t e;
        int c;
        pend = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 0;
            end else begin
                if (ke_step) chk("no_step_while_valid", 128'(rk_valid), 0);
                if (in_replay) chk("replay_no_strobes", 128'({ke_load, ke_step}), 0);
                if (rk_valid) begin
                    if (pend) chk("stall_data_stable", rk_data, prev_d);
                    if (rk_ready) begin
                        pend = 0;
                        if (q.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL unexpected_key: got idx %0d expected none", rk_idx);
                        end else begin
                            e = q.pop_front();
                            chk("rk_data", rk_data, e.d);
                            chk("rk_idx", 128'(rk_idx), 128'(e.idx));
                            if (e.cyc >= 0) chk("rk_cycle", 128'(cyc), 128'(e.cyc));
                        end
                    end else begin
                        pend = 1;
                        prev_d = rk_data;
                    end
                end
                if (done) begin
                    if (dq.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                    end else begin
                        c = dq.pop_front();
                        if (c >= 0) chk("done_cycle", 128'(cyc), 128'(c));
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        bit found;
        logic [127:0] k;
        n_vec = 0; n_err = 0; cyc = 0; rmode = 0; in_replay = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; replay = 1'b0; key = '0; rk_ready = 1'b1;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, b;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        chk_zero("idle");

        // FIPS-197 vector with rk_ready held high: exact cycle timing checked.
        rmode = 0;
        start_run(FKEY, 11, 1, 1, 1, s);
        wait_done();
        @(negedge clk);
        chk("idle_after_done", 128'(busy), 0);

        // Random keys under ~50% backpressure.
        rmode = 1;
        repeat (4) begin
            k = rnd128();
            start_run(k, 11, 0, 1, 0, s);
            wait_done();
            last_k = k;
        end

        // Abort together with start in IDLE: abort wins.
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; key = rnd128();
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("abort_vs_start_busy", 128'(busy), 0);
        chk("abort_vs_start_load", 128'(ke_load), 0);

        // Abort in the round-4 SBOX cycle.
        rmode = 0;
        start_run(rnd128(), 5, 1, 0, 0, s);
        while (cyc < s + 15) begin
            @(posedge clk); #1;
        end
        chk("sbox4_idx", 128'(rk_idx), 4);
        chk("sbox4_valid", 128'(rk_valid), 0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk_zero("after_abort");
        repeat (5) @(negedge clk);
        chk("abort_keys_drained", 128'(q.size()), 0);
        rmode = 1;
        k = rnd128();
        start_run(k, 11, 0, 1, 0, s);
        wait_done();

        // Asynchronous reset while round 7 is being emitted.
        start_run(rnd128(), 11, 0, 1, 0, s);
        found = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(posedge clk); #2;
            if (rk_valid && rk_idx == 4'd7) found = 1;
        end
        if (!found) begin
            n_vec++;
            n_err++;
            $display("FAIL round7_emit: got no round 7 expected round 7 valid");
        end
        rst = 1'b1;
        #1;
        chk_zero("async_reset");
        q.delete();
        dq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Fresh run after reset, with an extra start pulse while busy.
        k = rnd128();
        start_run(k, 11, 0, 1, 0, s);
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1; key = rnd128();
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        last_k = k;
        repeat (40) @(negedge clk);

`ifdef AES_KEY_CACHE_EN
        in_replay = 1;
        for (int r = 0; r < 11; r++) begin
            exp_t e;
            e.d = ref_key(last_k, r);
            e.idx = r;
            e.cyc = -1;
            q.push_back(e);
        end
        dq.push_back(-1);
        @(posedge clk); #1;
        replay = 1'b1;
        @(posedge clk); #1;
        replay = 1'b0;
        wait_done();
        @(negedge clk);
        in_replay = 0;
`else
        no_resp("replay_ignored");
`endif
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        no_resp("replay_after_abort");

        chk("keys_left", 128'(q.size()), 0);
        chk("dones_left", 128'(dq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
